// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW stall detection, branch flush sequencing and memory freeze for the 5-stage core
// Ports: clk/rst core clock and async active-low reset; id_valid/src1/src2/Two_src/id_WB_EN/id_MEM_R_EN/id_Dest
// describe the ID instruction; branch_taken from EXE; mem_busy from data memory; clr_cnt clears statistics;
// hazard/flush/freeze drive the pipeline; stall_cnt/flush_cnt are saturating statistics.
module pipeline_hazard_ctrl #(
  parameter bit FWD_EN       = 1'b0,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             Two_src,
  input  logic             id_WB_EN,
  input  logic             id_MEM_R_EN,
  input  logic [3:0]       id_Dest,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             clr_cnt,
  output logic             hazard,
  output logic             flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t r_state, w_state_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic r_exe_v, r_exe_wb, r_exe_mr, r_mem_v, r_mem_wb;
  logic [3:0] r_exe_dest, r_mem_dest;
  logic w_accept, w_exe_chk, w_mem_chk, w_exe_hit, w_mem_hit;
  assign freeze = mem_busy;
  // with forwarding only a load still in EXE cannot be bypassed
  assign w_exe_chk = r_exe_v && r_exe_wb && (!FWD_EN || r_exe_mr);
  assign w_mem_chk = !FWD_EN && r_mem_v && r_mem_wb;
  assign w_exe_hit = w_exe_chk && (src1 == r_exe_dest || (Two_src && src2 == r_exe_dest));
  assign w_mem_hit = w_mem_chk && (src1 == r_mem_dest || (Two_src && src2 == r_mem_dest));
  assign hazard = id_valid && (w_exe_hit || w_mem_hit) && !flush;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_accept   = r_state == RUN && branch_taken && !mem_busy;
    flush      = w_accept || r_state == FLUSH;
    if (w_accept && FLUSH_CYCLES > 1) begin
      w_state_nx = FLUSH;
      w_cnt_nx   = 3'(FLUSH_CYCLES - 1);
    end else if (r_state == FLUSH && !mem_busy) begin
      w_cnt_nx   = r_cnt - 3'd1;
      w_state_nx = r_cnt == 3'd1 ? RUN : FLUSH;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exe_v    <= 1'b0;
      r_exe_wb   <= 1'b0;
      r_exe_mr   <= 1'b0;
      r_exe_dest <= 4'd0;
      r_mem_v    <= 1'b0;
      r_mem_wb   <= 1'b0;
      r_mem_dest <= 4'd0;
    end else if (!mem_busy) begin
      r_mem_v    <= r_exe_v;
      r_mem_wb   <= r_exe_wb;
      r_mem_dest <= r_exe_dest;
      r_exe_v    <= id_valid && !hazard && !flush;
      r_exe_wb   <= id_WB_EN;
      r_exe_mr   <= id_MEM_R_EN;
      r_exe_dest <= id_Dest;
    end
  end
  // clear wins over increment and ignores freeze
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && !mem_busy && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      if (w_accept && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for two controller configurations sharing one stimulus stream
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid = 0, Two_src = 0, id_WB_EN = 0, id_MEM_R_EN = 0, branch_taken = 0, mem_busy = 0, clr_cnt = 0;
  logic [3:0] src1 = 0, src2 = 0, id_Dest = 0;
  logic haz0, fl0, frz0, haz1, fl1, frz1;
  logic [3:0] sc0, fc0;
  logic [15:0] sc1, fc1;
  localparam int H0 = 0, F0 = 1, Z0 = 2, S0 = 3, C0 = 4, H1 = 5, F1 = 6, S1 = 7, C1 = 8;
  typedef struct {string tag; int sel; int val;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.FWD_EN(1'b0), .FLUSH_CYCLES(3), .CNT_W(4)) d0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2), .Two_src(Two_src),
    .id_WB_EN(id_WB_EN), .id_MEM_R_EN(id_MEM_R_EN), .id_Dest(id_Dest), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .clr_cnt(clr_cnt), .hazard(haz0), .flush(fl0), .freeze(frz0),
    .stall_cnt(sc0), .flush_cnt(fc0));
  pipeline_hazard_ctrl #(.FWD_EN(1'b1), .FLUSH_CYCLES(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2), .Two_src(Two_src),
    .id_WB_EN(id_WB_EN), .id_MEM_R_EN(id_MEM_R_EN), .id_Dest(id_Dest), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .clr_cnt(clr_cnt), .hazard(haz1), .flush(fl1), .freeze(frz1),
    .stall_cnt(sc1), .flush_cnt(fc1));
  task automatic ex(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    q.push_back(e);
  endtask
  function automatic logic [31:0] obs(input int sel);
    case (sel)
      H0: obs = {31'd0, haz0};
      F0: obs = {31'd0, fl0};
      Z0: obs = {31'd0, frz0};
      S0: obs = {28'd0, sc0};
      C0: obs = {28'd0, fc0};
      H1: obs = {31'd0, haz1};
      F1: obs = {31'd0, fl1};
      S1: obs = {16'd0, sc1};
      C1: obs = {16'd0, fc1};
      default: obs = 32'hffff_ffff;
    endcase
  endfunction
  task automatic chk;
    exp_t e;
    logic [31:0] o;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, o, e.val);
      end
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ins(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                     input logic wb, input logic mr, input logic [3:0] d);
    id_valid = v; src1 = s1; src2 = s2; Two_src = two; id_WB_EN = wb; id_MEM_R_EN = mr; id_Dest = d;
  endtask
  task automatic drain;
    tick;
    ins(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
  endtask
  initial begin
    #3;
    ex("rst_h0", H0, 0); ex("rst_f0", F0, 0); ex("rst_s0", S0, 0); ex("rst_c0", C0, 0);
    ex("rst_h1", H1, 0); ex("rst_f1", F1, 0); ex("rst_s1", S1, 0); ex("rst_c1", C1, 0);
    chk;
    tick;
    rst = 1'b1;
    tick;
    // write R1 then read it: two stall cycles without forwarding, none with
    ins(1, 0, 0, 0, 1, 0, 1); ex("t1_issue_h0", H0, 0); chk;
    tick;
    ins(1, 1, 0, 0, 1, 0, 2); ex("t1_exe_h0", H0, 1); ex("t1_exe_h1", H1, 0); chk;
    tick; ex("t1_mem_h0", H0, 1); chk;
    tick; ex("t1_done_h0", H0, 0); ex("t1_s0", S0, 2); ex("t1_s1", S1, 0); chk;
    drain;
    // load-use through src2
    ins(1, 0, 0, 0, 1, 1, 3); ex("t2_ld_h1", H1, 0); chk;
    tick;
    ins(1, 0, 3, 1, 1, 0, 4); ex("t2_use_h1", H1, 1); ex("t2_use_h0", H0, 1); chk;
    tick; ex("t2_after_h1", H1, 0); ex("t2_s1", S1, 1); chk;
    drain;
    ins(1, 0, 0, 0, 1, 1, 3);
    tick;
    ins(1, 0, 3, 0, 1, 0, 4); ex("t2_one_src_h1", H1, 0); ex("t2_one_src_h0", H0, 0); chk;
    drain;
    ins(1, 0, 0, 0, 1, 0, 3);
    tick;
    ins(1, 0, 3, 1, 1, 0, 4); ex("t2_alu_h1", H1, 0); ex("t2_alu_h0", H0, 1); chk;
    drain;
    ex("t2_end_s1", S1, 1); chk;
    // three-cycle flush masks a matching source and leaves a bubble
    clr_cnt = 1;
    tick;
    clr_cnt = 0; ex("clr_s0", S0, 0); ex("clr_c0", C0, 0); ex("clr_s1", S1, 0); chk;
    ins(1, 0, 0, 0, 1, 0, 5);
    tick;
    ins(1, 5, 0, 0, 1, 0, 6); branch_taken = 1;
    ex("t3_c0_f0", F0, 1); ex("t3_c0_h0", H0, 0); ex("t3_c0_f1", F1, 1); ex("t3_c0_cnt", C0, 0); chk;
    tick;
    branch_taken = 0;
    ex("t3_c1_f0", F0, 1); ex("t3_c1_h0", H0, 0); ex("t3_c1_f1", F1, 0); ex("t3_c1_cnt0", C0, 1); ex("t3_c1_cnt1", C1, 1); chk;
    tick; ex("t3_c2_f0", F0, 1); ex("t3_c2_h0", H0, 0); chk;
    tick;
    ins(1, 6, 0, 0, 1, 0, 7); ex("t3_c3_f0", F0, 0); ex("t3_bubble_h0", H0, 0); ex("t3_s0", S0, 0); chk;
    drain;
    // freeze during a pending hazard; a branch while frozen is ignored
    ins(1, 0, 0, 0, 1, 0, 7);
    tick;
    ins(1, 7, 0, 0, 1, 0, 8); mem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      branch_taken = (i == 2);
      ex("t4_frz_z0", Z0, 1); ex("t4_frz_h0", H0, 1); ex("t4_frz_s0", S0, 0);
      ex("t4_frz_f0", F0, 0); ex("t4_frz_f1", F1, 0); ex("t4_frz_c0", C0, 1);
      chk;
      tick;
    end
    mem_busy = 0; branch_taken = 0;
    ex("t4_thaw_z0", Z0, 0); ex("t4_thaw_h0", H0, 1); ex("t4_thaw_s0", S0, 0); ex("t4_thaw_c0", C0, 1); ex("t4_thaw_c1", C1, 1); chk;
    tick; ex("t4_mem_h0", H0, 1); ex("t4_mem_s0", S0, 1); chk;
    tick; ex("t4_done_h0", H0, 0); ex("t4_done_s0", S0, 2); chk;
    drain;
    // 20 stall cycles saturate the 4-bit counter
    clr_cnt = 1;
    tick;
    clr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 7) begin
        ex("t5_s0_14", S0, 14); chk;
      end
      ins(1, 0, 0, 0, 1, 0, 8);
      tick;
      ins(1, 8, 0, 0, 1, 0, 9); ex("t5_h0", H0, 1); chk;
      tick;
      tick;
    end
    ex("t5_sat_s0", S0, 15); chk;
    ins(0, 0, 0, 0, 0, 0, 0); clr_cnt = 1; mem_busy = 1; ex("t5_clr_z0", Z0, 1); chk;
    tick;
    ex("t5_clr_s0", S0, 0); ex("t5_clr_c0", C0, 0); ex("t5_clr_c1", C1, 0); chk;
    clr_cnt = 0; mem_busy = 0;
    tick;
    // asynchronous reset in the middle of a flush
    ins(1, 0, 0, 0, 1, 0, 9);
    tick;
    ins(1, 9, 0, 0, 1, 0, 10); branch_taken = 1; ex("t6_br_f0", F0, 1); chk;
    tick;
    branch_taken = 0; ex("t6_mid_f0", F0, 1); ex("t6_mid_c0", C0, 1); chk;
    rst = 0;
    ex("t6_rst_f0", F0, 0); ex("t6_rst_h0", H0, 0); ex("t6_rst_s0", S0, 0); ex("t6_rst_c0", C0, 0);
    ex("t6_rst_f1", F1, 0); ex("t6_rst_c1", C1, 0); chk;
    tick;
    tick;
    rst = 1;
    ins(1, 9, 0, 0, 1, 0, 10); ex("t6_post_h0", H0, 0); ex("t6_post_f0", F0, 0); ex("t6_post_h1", H1, 0); chk;
    tick;
    ins(1, 10, 0, 0, 1, 0, 11); ex("t6_new_h0", H0, 1); chk;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
